// File: rtl/pll_reconfig_ctrl.sv
// rPLL bring-up sequencer: reset pulse, lock wait with timeout/retry, lock qualification,
// core reset gating, runtime divider reconfiguration and lock-loss counting.
module pll_reconfig_ctrl #(
  parameter logic [5:0]  INIT_IDSEL   = 6'd7,
  parameter logic [5:0]  INIT_FBDSEL  = 6'd18,
  parameter logic [5:0]  INIT_ODSEL   = 6'd8,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       cfg_req,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  output logic       cfg_ready,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       core_rst,
  output logic       locked,
  output logic       pll_err,
  output logic [7:0] lost_cnt
);

  localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CNT = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
  localparam int unsigned CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);
  localparam int unsigned RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // The lk=1 cycle seen in WAIT_LOCK is the first qualified cycle, so STABLE needs one fewer
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'((LOCK_STABLE >= 2) ? LOCK_STABLE - 2 : 0);
  localparam logic             SKIP_STABLE  = (LOCK_STABLE < 2);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'((MAX_RETRY >= 1) ? MAX_RETRY - 1 : 0);

  typedef enum logic [2:0] {
    ST_RST_ASSERT,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  typedef struct packed {
    logic pll_reset;
    logic core_rst;
    logic locked;
    logic pll_err;
    logic cfg_ready;
  } flags_t;

  // Registered status flags are loaded from the state being entered
  function automatic flags_t flags_of(input state_t s);
    flags_t f;
    f = '{pll_reset: 1'b1, core_rst: 1'b1, locked: 1'b0, pll_err: 1'b0, cfg_ready: 1'b0};
    case (s)
      ST_WAIT_LOCK, ST_STABLE: f.pll_reset = 1'b0;
      ST_RUN: begin
        f.pll_reset = 1'b0;
        f.core_rst  = 1'b0;
        f.locked    = 1'b1;
        f.cfg_ready = 1'b1;
      end
      ST_FAIL: begin
        f.pll_err   = 1'b1;
        f.cfg_ready = 1'b1;
      end
      default: ;
    endcase
    return f;
  endfunction

  state_t             state;
  flags_t             flags;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic               sync1;
  logic               lk;

  assign pll_reset = flags.pll_reset;
  assign core_rst  = flags.core_rst;
  assign locked    = flags.locked;
  assign pll_err   = flags.pll_err;
  assign cfg_ready = flags.cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RST_ASSERT;
      flags      <= flags_of(ST_RST_ASSERT);
      cnt        <= '0;
      retry      <= '0;
      sync1      <= 1'b0;
      lk         <= 1'b0;
      lost_cnt   <= '0;
      pll_idsel  <= INIT_IDSEL;
      pll_fbdsel <= INIT_FBDSEL;
      pll_odsel  <= INIT_ODSEL;
    end else begin
      sync1 <= pll_lock;
      lk    <= sync1;

      // Lock loss is counted even when a config request wins the same cycle
      if (state == ST_RUN && !lk && lost_cnt != 8'hFF) begin
        lost_cnt <= lost_cnt + 8'd1;
      end

      if (cfg_ready && cfg_req) begin
        pll_idsel  <= cfg_idsel;
        pll_fbdsel <= cfg_fbdsel;
        pll_odsel  <= cfg_odsel;
        retry      <= '0;
        cnt        <= '0;
        state      <= ST_RST_ASSERT;
        flags      <= flags_of(ST_RST_ASSERT);
      end else begin
        case (state)
          ST_RST_ASSERT: begin
            if (cnt == RST_LAST) begin
              cnt   <= '0;
              state <= ST_WAIT_LOCK;
              flags <= flags_of(ST_WAIT_LOCK);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          ST_WAIT_LOCK: begin
            if (lk) begin
              cnt <= '0;
              if (SKIP_STABLE) begin
                retry <= '0;
                state <= ST_RUN;
                flags <= flags_of(ST_RUN);
              end else begin
                state <= ST_STABLE;
                flags <= flags_of(ST_STABLE);
              end
            end else if (cnt == TIMEOUT_LAST) begin
              cnt   <= '0;
              retry <= retry + RETRY_W'(1);
              if (retry == RETRY_LAST) begin
                state <= ST_FAIL;
                flags <= flags_of(ST_FAIL);
              end else begin
                state <= ST_RST_ASSERT;
                flags <= flags_of(ST_RST_ASSERT);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          ST_STABLE: begin
            if (!lk) begin
              cnt   <= '0;
              state <= ST_WAIT_LOCK;
              flags <= flags_of(ST_WAIT_LOCK);
            end else if (cnt == STABLE_LAST) begin
              cnt   <= '0;
              retry <= '0;
              state <= ST_RUN;
              flags <= flags_of(ST_RUN);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          ST_RUN: begin
            if (!lk) begin
              cnt   <= '0;
              state <= ST_RST_ASSERT;
              flags <= flags_of(ST_RST_ASSERT);
            end
          end

          ST_FAIL: ;

          default: begin
            cnt   <= '0;
            state <= ST_RST_ASSERT;
            flags <= flags_of(ST_RST_ASSERT);
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Sequences the board rPLL (27 MHz in, core clock out): reset pulse, lock wait and lock qualification, with a timeout and a bounded retry count.
- Gates the core reset until the PLL has been stably locked.
- Accepts runtime requests for new IDSEL/FBDSEL/ODSEL divider values and reports lock loss.
- Runs on the PLL input clock, so it stays alive while the PLL output is invalid.

Parameters:
- INIT_IDSEL, 7, divider select driven out of reset (6 bits, passed to the PLL unmodified)
- INIT_FBDSEL, 18, feedback divider select out of reset
- INIT_ODSEL, 8, output divider select out of reset
- RST_CYCLES, 16, cycles pll_reset is held high per attempt (must be at least 1)
- LOCK_TIMEOUT, 65535, maximum cycles to wait for synchronised lock before an attempt fails
- LOCK_STABLE, 1024, consecutive synchronised-lock cycles required before release
- MAX_RETRY, 3, failed attempts allowed before entering FAIL

Ports:
- clk  in  1  PLL reference clock (27 MHz), free-running
- rst  in  1  synchronous, active-high reset
- pll_lock  in  1  PLL LOCK; asynchronous, synchronised internally through 2 flops
- cfg_req  in  1  request to apply new divider values; accepted only when cfg_ready=1
- cfg_idsel  in  6  new IDSEL, sampled on acceptance
- cfg_fbdsel  in  6  new FBDSEL, sampled on acceptance
- cfg_odsel  in  6  new ODSEL, sampled on acceptance
- cfg_ready  out  1  high in RUN and FAIL
- pll_reset  out  1  to PLL RESET
- pll_idsel  out  6  to PLL IDSEL, registered
- pll_fbdsel  out  6  to PLL FBDSEL, registered
- pll_odsel  out  6  to PLL ODSEL, registered
- core_rst  out  1  active-high reset for the clkout domain; the consumer synchronises it
- locked  out  1  high only in RUN
- pll_err  out  1  high only in FAIL
- lost_cnt  out  8  count of lock-loss events in RUN; saturates at 255

Behaviour:
- Reset values:
  - state=RST_ASSERT, pll_reset=1, core_rst=1, locked=0, pll_err=0, cfg_ready=0.
  - pll_* selects = INIT_* parameters; lost_cnt=0, retry counter=0, sync flops=0.
- Definition: lk = 2-flop-synchronised pll_lock. All decisions use lk only.
- RST_ASSERT:
  - pll_reset=1, core_rst=1.
  - Counter runs RST_CYCLES cycles, then → WAIT_LOCK with the counter cleared.
- WAIT_LOCK:
  - pll_reset=0, core_rst=1.
  - lk=1 → STABLE with the counter cleared.
  - Counter reaches LOCK_TIMEOUT with lk still 0 → the attempt fails:
    - retry counter incremented;
    - if the new retry count equals MAX_RETRY → FAIL, otherwise → RST_ASSERT.
- STABLE:
  - core_rst=1.
  - Counter increments while lk=1.
  - lk=0 → back to WAIT_LOCK with the counter cleared. This is not a failure; the timeout counter restarts.
  - Counter reaches LOCK_STABLE → RUN; retry counter cleared.
- RUN:
  - core_rst=0, locked=1, cfg_ready=1.
  - lk=0 → RST_ASSERT; lost_cnt incremented unless already 255; core_rst goes to 1 on the next edge.
- FAIL:
  - pll_reset=1, core_rst=1, pll_err=1, cfg_ready=1.
  - Held until rst or an accepted cfg_req.
- Config handshake:
  - cfg_req=1 while cfg_ready=1 → on that edge, cfg_* are latched into pll_*, retry counter cleared, state → RST_ASSERT.
  - cfg_ready drops on the same edge; the request is single-cycle.
  - cfg_req while cfg_ready=0 is ignored and not queued.
- Simultaneous events in RUN: cfg_req and lk=0 in the same cycle → the config is accepted and lost_cnt is still incremented.
- pll_* selects change only on reset or on config acceptance, and only while pll_reset is high or about to go high.
- Counter widths are sized by $clog2 of the largest count parameter. No counter wraps: every count compares for equality and then clears.
- rst asserted mid-sequence → all state returns to reset values on the next edge, including the selects reverting to INIT_*.

Test Plan (sim params RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2):
- Power-up, pll_lock driven high 10 cycles after rst falls:
  - pll_reset high for 4 cycles after rst;
  - core_rst falls exactly 2 (sync) + 8 cycles after lock rises;
  - locked=1, selects = 7/18/8.
- Lock glitch: lock low for 3 cycles at cycle 5 of STABLE → returns to WAIT_LOCK; core_rst stays 1; stable count restarts from 0.
- Lock never asserted:
  - two timeouts of 20 cycles, each preceded by a 4-cycle pll_reset;
  - then pll_err=1, pll_reset=1, cfg_ready=1.
  - cfg_req with 1/9/4 → pll_err=0 and the sequence restarts with the new selects.
- In RUN, cfg_req with 3/31/2, lock held high → selects update on the acceptance edge; pll_reset pulses for 4 cycles; locked returns after requalification.
- In RUN, lock drops 3 times → lost_cnt=3; core_rst rises 3 cycles after each drop (2 sync + 1).
- rst pulsed during WAIT_LOCK after a reconfig to 3/31/2 → selects revert to 7/18/8; state returns to RST_ASSERT; lost_cnt=0.
